control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer_pkg.sv | 119 +++++++++++
 rtl/control_sequencer_reg_decode.sv | 16 +
 rtl/control_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared encodings for the control sequencer: states, opcodes, IR field positions, control bundle.
// Pure declarations and decode helpers; no timing or flow control of its own.
package control_sequencer_pkg;

   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_T0   = 4'd1,
      ST_T1   = 4'd2,
      ST_T2   = 4'd3,
      ST_T3   = 4'd4,
      ST_T4   = 4'd5,
      ST_T5   = 4'd6,
      ST_T6   = 4'd7,
      ST_HALT = 4'd8
   } state_t;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 27;
   localparam int RA_MSB  = 26;
   localparam int RA_LSB  = 23;
   localparam int RB_MSB  = 22;
   localparam int RB_LSB  = 19;
   localparam int RC_MSB  = 18;
   localparam int RC_LSB  = 15;

   localparam logic [4:0] OPC_ADD  = 5'b00011;
   localparam logic [4:0] OPC_SUB  = 5'b00100;
   localparam logic [4:0] OPC_AND  = 5'b00101;
   localparam logic [4:0] OPC_OR   = 5'b00110;
   localparam logic [4:0] OPC_SHR  = 5'b00111;
   localparam logic [4:0] OPC_SHRA = 5'b01000;
   localparam logic [4:0] OPC_SHL  = 5'b01001;
   localparam logic [4:0] OPC_ROR  = 5'b01010;
   localparam logic [4:0] OPC_ROL  = 5'b01011;
   localparam logic [4:0] OPC_MUL  = 5'b01111;
   localparam logic [4:0] OPC_DIV  = 5'b10000;
   localparam logic [4:0] OPC_NEG  = 5'b10001;
   localparam logic [4:0] OPC_NOT  = 5'b10010;

   localparam int ALU_W    = 13;
   localparam int ALU_ADD  = 0;
   localparam int ALU_SUB  = 1;
   localparam int ALU_AND  = 2;
   localparam int ALU_OR   = 3;
   localparam int ALU_SHR  = 4;
   localparam int ALU_SHRA = 5;
   localparam int ALU_SHL  = 6;
   localparam int ALU_ROR  = 7;
   localparam int ALU_ROL  = 8;
   localparam int ALU_MUL  = 9;
   localparam int ALU_DIV  = 10;
   localparam int ALU_NEG  = 11;
   localparam int ALU_NOT  = 12;

   // Execute-phase shape of an instruction; drives the T3..T6 schedule.
   typedef enum logic [1:0] {
      CLS_ILLEGAL = 2'd0,
      CLS_TRIADIC = 2'd1,
      CLS_UNARY   = 2'd2,
      CLS_MULDIV  = 2'd3
   } op_class_t;

   typedef struct packed {
      logic             pc_out;
      logic             mdr_out;
      logic             zhigh_out;
      logic             zlow_out;
      logic             hi_out;
      logic             lo_out;
      logic             pc_in;
      logic             mar_in;
      logic             mdr_in;
      logic             ir_in;
      logic             z_in;
      logic             y_in;
      logic             hi_in;
      logic             lo_in;
      logic             inc_pc;
      logic             read;
      logic [ALU_W-1:0] alu;
      logic             rout_en;
      logic [3:0]       rout_idx;
      logic             rin_en;
      logic [3:0]       rin_idx;
      logic             done;
      logic             halted;
   } ctl_t;

   function automatic op_class_t op_class(input logic [4:0] opc);
      case (opc)
         OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_SHR,
         OPC_SHRA, OPC_SHL, OPC_ROR, OPC_ROL:  op_class = CLS_TRIADIC;
         OPC_NEG, OPC_NOT:                     op_class = CLS_UNARY;
         OPC_MUL, OPC_DIV:                     op_class = CLS_MULDIV;
         default:                              op_class = CLS_ILLEGAL;
      endcase
   endfunction

   function automatic logic [ALU_W-1:0] alu_select(input logic [4:0] opc);
      alu_select = '0;
      case (opc)
         OPC_ADD:  alu_select[ALU_ADD]  = 1'b1;
         OPC_SUB:  alu_select[ALU_SUB]  = 1'b1;
         OPC_AND:  alu_select[ALU_AND]  = 1'b1;
         OPC_OR:   alu_select[ALU_OR]   = 1'b1;
         OPC_SHR:  alu_select[ALU_SHR]  = 1'b1;
         OPC_SHRA: alu_select[ALU_SHRA] = 1'b1;
         OPC_SHL:  alu_select[ALU_SHL]  = 1'b1;
         OPC_ROR:  alu_select[ALU_ROR]  = 1'b1;
         OPC_ROL:  alu_select[ALU_ROL]  = 1'b1;
         OPC_MUL:  alu_select[ALU_MUL]  = 1'b1;
         OPC_DIV:  alu_select[ALU_DIV]  = 1'b1;
         OPC_NEG:  alu_select[ALU_NEG]  = 1'b1;
         OPC_NOT:  alu_select[ALU_NOT]  = 1'b1;
         default:  alu_select = '0;
      endcase
   endfunction

endpackage

// File: rtl/control_sequencer_reg_decode.sv
// Register-file select decoder: 4-bit index plus enable to a 16-bit one-hot (all zero when disabled).
// Purely combinational, zero latency; no flow control.
module reg_decode (
   input  logic [3:0]  idx,
   input  logic        en,
   output logic [15:0] onehot
);

   always_comb begin
      onehot = '0;
      if (en) begin
         onehot[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch T0-T2, opcode-shaped execute T3-T6, sticky HALT on an illegal opcode.
// Latency 5-7 cycles per instruction; no backpressure, Run is sampled in IDLE and Stop at the Done step.
module control_sequencer
   import control_sequencer_pkg::*;
(
   input  logic        Clock,
   input  logic        Clear,
   input  logic        Run,
   input  logic        Stop,
   input  logic [31:0] IR,
   output logic        PCout,
   output logic        MDRout,
   output logic        Zhighout,
   output logic        Zlowout,
   output logic        HIout,
   output logic        LOout,
   output logic        PCin,
   output logic        MARin,
   output logic        MDRin,
   output logic        IRin,
   output logic        Zin,
   output logic        Yin,
   output logic        HIin,
   output logic        LOin,
   output logic        IncPC,
   output logic        Read,
   output logic        ADD,
   output logic        SUB,
   output logic        AND,
   output logic        OR,
   output logic        SHR,
   output logic        SHRA,
   output logic        SHL,
   output logic        ROR,
   output logic        ROL,
   output logic        MUL,
   output logic        DIV,
   output logic        NEG,
   output logic        NOT,
   output logic [15:0] Rout,
   output logic [15:0] Rin,
   output logic        Done,
   output logic        Halted
);

   state_t     state;
   state_t     state_nxt;
   ctl_t       ctl;
   logic [4:0] opc;
   logic [3:0] ra;
   logic [3:0] rb;
   logic [3:0] rc;
   op_class_t  cls;
   logic       ir_unused;

   assign opc       = IR[OPC_MSB:OPC_LSB];
   assign ra        = IR[RA_MSB:RA_LSB];
   assign rb        = IR[RB_MSB:RB_LSB];
   assign rc        = IR[RC_MSB:RC_LSB];
   assign cls       = op_class(opc);
   assign ir_unused = ^IR[RC_LSB-1:0];

   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Outputs depend only on state and IR; IR is trusted from T3 onward.
   always_comb begin
      ctl       = '0;
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (Run) state_nxt = ST_T0;
         end
         ST_T0: begin
            ctl.pc_out = 1'b1;
            ctl.mar_in = 1'b1;
            ctl.inc_pc = 1'b1;
            ctl.z_in   = 1'b1;
            state_nxt  = ST_T1;
         end
         ST_T1: begin
            ctl.zlow_out = 1'b1;
            ctl.pc_in    = 1'b1;
            ctl.read     = 1'b1;
            ctl.mdr_in   = 1'b1;
            state_nxt    = ST_T2;
         end
         ST_T2: begin
            ctl.mdr_out = 1'b1;
            ctl.ir_in   = 1'b1;
            state_nxt   = ST_T3;
         end
         ST_T3: begin
            case (cls)
               CLS_TRIADIC: begin
                  ctl.rout_en  = 1'b1;
                  ctl.rout_idx = rb;
                  ctl.y_in     = 1'b1;
                  state_nxt    = ST_T4;
               end
               CLS_UNARY: begin
                  ctl.rout_en  = 1'b1;
                  ctl.rout_idx = rb;
                  ctl.alu      = alu_select(opc);
                  ctl.z_in     = 1'b1;
                  state_nxt    = ST_T4;
               end
               CLS_MULDIV: begin
                  ctl.rout_en  = 1'b1;
                  ctl.rout_idx = ra;
                  ctl.y_in     = 1'b1;
                  state_nxt    = ST_T4;
               end
               default: state_nxt = ST_HALT;
            endcase
         end
         ST_T4: begin
            case (cls)
               CLS_TRIADIC: begin
                  ctl.rout_en  = 1'b1;
                  ctl.rout_idx = rc;
                  ctl.alu      = alu_select(opc);
                  ctl.z_in     = 1'b1;
                  state_nxt    = ST_T5;
               end
               CLS_UNARY: begin
                  ctl.zlow_out = 1'b1;
                  ctl.rin_en   = 1'b1;
                  ctl.rin_idx  = ra;
                  ctl.done     = 1'b1;
                  state_nxt    = Stop ? ST_IDLE : ST_T0;
               end
               CLS_MULDIV: begin
                  ctl.rout_en  = 1'b1;
                  ctl.rout_idx = rb;
                  ctl.alu      = alu_select(opc);
                  ctl.z_in     = 1'b1;
                  state_nxt    = ST_T5;
               end
               default: state_nxt = ST_HALT;
            endcase
         end
         ST_T5: begin
            case (cls)
               CLS_TRIADIC: begin
                  ctl.zlow_out = 1'b1;
                  ctl.rin_en   = 1'b1;
                  ctl.rin_idx  = ra;
                  ctl.done     = 1'b1;
                  state_nxt    = Stop ? ST_IDLE : ST_T0;
               end
               CLS_MULDIV: begin
                  ctl.zlow_out = 1'b1;
                  ctl.lo_in    = 1'b1;
                  state_nxt    = ST_T6;
               end
               default: state_nxt = ST_HALT;
            endcase
         end
         ST_T6: begin
            if (cls == CLS_MULDIV) begin
               ctl.zhigh_out = 1'b1;
               ctl.hi_in     = 1'b1;
               ctl.done      = 1'b1;
               state_nxt     = Stop ? ST_IDLE : ST_T0;
            end else begin
               state_nxt = ST_HALT;
            end
         end
         ST_HALT: begin
            ctl.halted = 1'b1;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   reg_decode u_rout_dec (
      .idx    (ctl.rout_idx),
      .en     (ctl.rout_en),
      .onehot (Rout)
   );

   reg_decode u_rin_dec (
      .idx    (ctl.rin_idx),
      .en     (ctl.rin_en),
      .onehot (Rin)
   );

   assign PCout    = ctl.pc_out;
   assign MDRout   = ctl.mdr_out;
   assign Zhighout = ctl.zhigh_out;
   assign Zlowout  = ctl.zlow_out;
   assign HIout    = ctl.hi_out;
   assign LOout    = ctl.lo_out;
   assign PCin     = ctl.pc_in;
   assign MARin    = ctl.mar_in;
   assign MDRin    = ctl.mdr_in;
   assign IRin     = ctl.ir_in;
   assign Zin      = ctl.z_in;
   assign Yin      = ctl.y_in;
   assign HIin     = ctl.hi_in;
   assign LOin     = ctl.lo_in;
   assign IncPC    = ctl.inc_pc;
   assign Read     = ctl.read;
   assign ADD      = ctl.alu[ALU_ADD];
   assign SUB      = ctl.alu[ALU_SUB];
   assign AND      = ctl.alu[ALU_AND];
   assign OR       = ctl.alu[ALU_OR];
   assign SHR      = ctl.alu[ALU_SHR];
   assign SHRA     = ctl.alu[ALU_SHRA];
   assign SHL      = ctl.alu[ALU_SHL];
   assign ROR      = ctl.alu[ALU_ROR];
   assign ROL      = ctl.alu[ALU_ROL];
   assign MUL      = ctl.alu[ALU_MUL];
   assign DIV      = ctl.alu[ALU_DIV];
   assign NEG      = ctl.alu[ALU_NEG];
   assign NOT      = ctl.alu[ALU_NOT];
   assign Done     = ctl.done;
   assign Halted   = ctl.halted;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-scenario tasks with hand-computed step tables.
// A negedge monitor also watches bus-driver and ALU-select exclusivity every cycle.
module tb_control_sequencer;
   import control_sequencer_pkg::*;

   logic        Clock = 1'b0;
   logic        Clear = 1'b1;
   logic        Run   = 1'b0;
   logic        Stop  = 1'b0;
   logic [31:0] IR    = 32'h0;
   logic PCout, MDRout, Zhighout, Zlowout, HIout, LOout;
   logic PCin, MARin, MDRin, IRin, Zin, Yin, HIin, LOin, IncPC, Read;
   logic ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, MUL, DIV, NEG, NOT;
   logic [15:0] Rout, Rin;
   logic Done, Halted;

   int n_tests = 0;
   int n_fail  = 0;

   control_sequencer dut (
      .Clock(Clock), .Clear(Clear), .Run(Run), .Stop(Stop), .IR(IR),
      .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout),
      .HIout(HIout), .LOout(LOout), .PCin(PCin), .MARin(MARin), .MDRin(MDRin),
      .IRin(IRin), .Zin(Zin), .Yin(Yin), .HIin(HIin), .LOin(LOin), .IncPC(IncPC),
      .Read(Read), .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .SHR(SHR),
      .SHRA(SHRA), .SHL(SHL), .ROR(ROR), .ROL(ROL), .MUL(MUL), .DIV(DIV),
      .NEG(NEG), .NOT(NOT), .Rout(Rout), .Rin(Rin), .Done(Done), .Halted(Halted)
   );

   always #5 Clock = ~Clock;

   logic [30:0] flags;
   logic [12:0] alu;
   assign alu   = {ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, MUL, DIV, NEG, NOT};
   assign flags = {PCout, MDRout, Zhighout, Zlowout, HIout, LOout,
                   PCin, MARin, MDRin, IRin, Zin, Yin, HIin, LOin, IncPC, Read,
                   alu, Done, Halted};

   localparam logic [30:0] M_PCOUT    = 31'h1 << 30;
   localparam logic [30:0] M_MDROUT   = 31'h1 << 29;
   localparam logic [30:0] M_ZHIGHOUT = 31'h1 << 28;
   localparam logic [30:0] M_ZLOWOUT  = 31'h1 << 27;
   localparam logic [30:0] M_PCIN     = 31'h1 << 24;
   localparam logic [30:0] M_MARIN    = 31'h1 << 23;
   localparam logic [30:0] M_MDRIN    = 31'h1 << 22;
   localparam logic [30:0] M_IRIN     = 31'h1 << 21;
   localparam logic [30:0] M_ZIN      = 31'h1 << 20;
   localparam logic [30:0] M_YIN      = 31'h1 << 19;
   localparam logic [30:0] M_HIIN     = 31'h1 << 18;
   localparam logic [30:0] M_LOIN     = 31'h1 << 17;
   localparam logic [30:0] M_INCPC    = 31'h1 << 16;
   localparam logic [30:0] M_READ     = 31'h1 << 15;
   localparam logic [30:0] M_ADD      = 31'h1 << 14;
   localparam logic [30:0] M_SUB      = 31'h1 << 13;
   localparam logic [30:0] M_AND      = 31'h1 << 12;
   localparam logic [30:0] M_MUL      = 31'h1 << 5;
   localparam logic [30:0] M_NEG      = 31'h1 << 3;
   localparam logic [30:0] M_DONE     = 31'h1 << 1;
   localparam logic [30:0] M_HALTED   = 31'h1 << 0;
   localparam logic [30:0] F_T0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
   localparam logic [30:0] F_T1 = M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN;
   localparam logic [30:0] F_T2 = M_MDROUT | M_IRIN;

   // Exclusivity monitor, every cycle of every scenario.
   int drivers;
   always @(negedge Clock) begin
      drivers = int'(PCout) + int'(MDRout) + int'(Zhighout) + int'(Zlowout)
              + int'(HIout) + int'(LOout) + $countones(Rout);
      n_tests++;
      if (drivers > 1) begin
         n_fail++;
         $display("FAIL bus_drivers t=%0t: got %0d drivers, want at most 1", $time, drivers);
      end
      n_tests++;
      if ($countones(alu) > 1) begin
         n_fail++;
         $display("FAIL alu_onehot t=%0t: got %b, want one-hot or zero", $time, alu);
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      state_t st[5];
      st = '{ST_T0, ST_T1, ST_T2, ST_T3, ST_T4};
      #2 Clear = 1'b0;
      #1;
      n_tests++;
      if (flags !== 31'h0 || Rout !== 16'h0 || Rin !== 16'h0 || dut.state !== ST_IDLE) begin
         n_fail++;
         $display("FAIL reset_init: flags=%h Rout=%h Rin=%h state=%0d, want all 0 and IDLE",
                  flags, Rout, Rin, dut.state);
      end
      // add R1,R2,R3 started on the first edge after release
      @(negedge Clock);
      Clear = 1'b1; Run = 1'b1; Stop = 1'b1; IR = 32'h18918000;
      for (int i = 0; i < 5; i++) begin
         @(posedge Clock); @(negedge Clock);
         n_tests++;
         if (dut.state !== st[i]) begin
            n_fail++;
            $display("FAIL reset_seq_state[%0d]: got %0d want %0d", i, dut.state, st[i]);
         end
      end
      n_tests++;
      if (flags !== (M_ADD | M_ZIN) || Rout !== 16'h0008) begin
         n_fail++;
         $display("FAIL reset_add_t4: flags=%h Rout=%h, want %h 0008", flags, Rout, M_ADD | M_ZIN);
      end
      #2 Clear = 1'b0;
      #1;
      n_tests++;
      if (flags !== 31'h0 || Rout !== 16'h0 || Rin !== 16'h0 || dut.state !== ST_IDLE || Halted !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_instr: flags=%h Rout=%h Rin=%h state=%0d, want 0 and IDLE",
                  flags, Rout, Rin, dut.state);
      end
      @(posedge Clock); @(negedge Clock);
      n_tests++;
      if (dut.state !== ST_IDLE) begin
         n_fail++;
         $display("FAIL reset_held: state=%0d want %0d", dut.state, ST_IDLE);
      end
      Clear = 1'b1; Run = 1'b0; Stop = 1'b0;
      @(posedge Clock); @(negedge Clock);
      n_tests++;
      if (dut.state !== ST_IDLE || flags !== 31'h0) begin
         n_fail++;
         $display("FAIL idle_no_run: state=%0d flags=%h want IDLE and 0", dut.state, flags);
      end
   endtask

   task automatic test_and();
      state_t      st[7];
      logic [30:0] fl[7];
      logic [15:0] ro[7];
      logic [15:0] ri[7];
      st = '{ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_IDLE};
      fl = '{F_T0, F_T1, F_T2, M_YIN, M_AND | M_ZIN, M_ZLOWOUT | M_DONE, 31'h0};
      ro = '{16'h0, 16'h0, 16'h0, 16'h0004, 16'h0008, 16'h0, 16'h0};
      ri = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0002, 16'h0};
      IR = 32'h28918000; Run = 1'b1; Stop = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(posedge Clock); @(negedge Clock);
         n_tests++;
         if (dut.state !== st[i]) begin
            n_fail++; $display("FAIL and_state[%0d]: got %0d want %0d", i, dut.state, st[i]);
         end
         n_tests++;
         if (flags !== fl[i]) begin
            n_fail++; $display("FAIL and_flags[%0d]: got %h want %h", i, flags, fl[i]);
         end
         n_tests++;
         if (Rout !== ro[i] || Rin !== ri[i]) begin
            n_fail++; $display("FAIL and_regs[%0d]: Rout=%h Rin=%h want %h %h", i, Rout, Rin, ro[i], ri[i]);
         end
      end
      Run = 1'b0;
   endtask

   task automatic test_neg();
      state_t      st[6];
      logic [30:0] fl[6];
      logic [15:0] ro[6];
      logic [15:0] ri[6];
      st = '{ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_IDLE};
      fl = '{F_T0, F_T1, F_T2, M_NEG | M_ZIN, M_ZLOWOUT | M_DONE, 31'h0};
      ro = '{16'h0, 16'h0, 16'h0, 16'h1000, 16'h0, 16'h0};
      ri = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0002, 16'h0};
      IR = 32'h88E00000; Run = 1'b1; Stop = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge Clock); @(negedge Clock);
         n_tests++;
         if (dut.state !== st[i]) begin
            n_fail++; $display("FAIL neg_state[%0d]: got %0d want %0d", i, dut.state, st[i]);
         end
         n_tests++;
         if (flags !== fl[i]) begin
            n_fail++; $display("FAIL neg_flags[%0d]: got %h want %h", i, flags, fl[i]);
         end
         n_tests++;
         if (Rout !== ro[i] || Rin !== ri[i]) begin
            n_fail++; $display("FAIL neg_regs[%0d]: Rout=%h Rin=%h want %h %h", i, Rout, Rin, ro[i], ri[i]);
         end
         if (i == 0) Run = 1'b0;   // dropping Run must not abort the instruction
      end
   endtask

   task automatic test_back_to_back();
      state_t      st[14];
      logic [30:0] fl[14];
      logic [15:0] ro[14];
      logic [15:0] ri[14];
      st = '{ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6,
             ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_IDLE};
      fl = '{F_T0, F_T1, F_T2, M_YIN, M_MUL | M_ZIN, M_ZLOWOUT | M_LOIN,
             M_ZHIGHOUT | M_HIIN | M_DONE,
             F_T0, F_T1, F_T2, M_YIN, M_SUB | M_ZIN, M_ZLOWOUT | M_DONE, 31'h0};
      ro = '{16'h0, 16'h0, 16'h0, 16'h0008, 16'h0010, 16'h0, 16'h0,
             16'h0, 16'h0, 16'h0, 16'h8000, 16'h0001, 16'h0, 16'h0};
      ri = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
             16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0001, 16'h0};
      // mul R3,R4 with Stop=0, then sub R0,R15,R0 with Stop=1
      IR = 32'h79A00000; Run = 1'b1; Stop = 1'b0;
      for (int i = 0; i < 14; i++) begin
         @(posedge Clock); @(negedge Clock);
         n_tests++;
         if (dut.state !== st[i]) begin
            n_fail++; $display("FAIL b2b_state[%0d]: got %0d want %0d", i, dut.state, st[i]);
         end
         n_tests++;
         if (flags !== fl[i]) begin
            n_fail++; $display("FAIL b2b_flags[%0d]: got %h want %h", i, flags, fl[i]);
         end
         n_tests++;
         if (Rout !== ro[i] || Rin !== ri[i]) begin
            n_fail++; $display("FAIL b2b_regs[%0d]: Rout=%h Rin=%h want %h %h", i, Rout, Rin, ro[i], ri[i]);
         end
         if (i == 7) begin
            IR = 32'h20780000; Stop = 1'b1; Run = 1'b0;
         end
      end
   endtask

   task automatic test_halt();
      state_t      st[5];
      logic [30:0] fl[5];
      st = '{ST_T0, ST_T1, ST_T2, ST_T3, ST_HALT};
      fl = '{F_T0, F_T1, F_T2, 31'h0, M_HALTED};
      IR = 32'hF8000000; Run = 1'b1; Stop = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge Clock); @(negedge Clock);
         n_tests++;
         if (dut.state !== st[i]) begin
            n_fail++; $display("FAIL halt_state[%0d]: got %0d want %0d", i, dut.state, st[i]);
         end
         n_tests++;
         if (flags !== fl[i] || Rout !== 16'h0 || Rin !== 16'h0) begin
            n_fail++; $display("FAIL halt_flags[%0d]: flags=%h Rout=%h Rin=%h want %h 0 0",
                               i, flags, Rout, Rin, fl[i]);
         end
      end
      for (int i = 0; i < 20; i++) begin
         @(posedge Clock); @(negedge Clock);
         n_tests++;
         if (dut.state !== ST_HALT || flags !== M_HALTED || Rout !== 16'h0 || Rin !== 16'h0) begin
            n_fail++; $display("FAIL halt_sticky[%0d]: state=%0d flags=%h want %0d %h",
                               i, dut.state, flags, ST_HALT, M_HALTED);
         end
      end
      #2 Clear = 1'b0;
      #1;
      n_tests++;
      if (Halted !== 1'b0 || dut.state !== ST_IDLE || flags !== 31'h0) begin
         n_fail++; $display("FAIL halt_clear: Halted=%b state=%0d flags=%h want 0 IDLE 0",
                            Halted, dut.state, flags);
      end
      @(negedge Clock);
      Clear = 1'b1; Run = 1'b0;
      @(posedge Clock); @(negedge Clock);
      n_tests++;
      if (dut.state !== ST_IDLE || Halted !== 1'b0) begin
         n_fail++; $display("FAIL halt_after_clear: state=%0d Halted=%b want IDLE 0", dut.state, Halted);
      end
   endtask

   initial begin
      test_reset();
      test_and();
      test_neg();
      test_back_to_back();
      test_halt();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
